// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock LSB first, under a start/busy/done handshake.

module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
  logic             c_r, s_bit, c_nxt;
  logic [CW-1:0]    cnt;

  serial_adder_fa u_fa (
    .x (a_r[0]),
    .y (b_r[0]),
    .ci(c_r),
    .s (s_bit),
    .co(c_nxt)
  );

  // Result fills from the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res1
      assign res_nxt = s_bit;
    end else begin : g_resn
      assign res_nxt = {s_bit, res[WIDTH-1:1]};
    end
  endgenerate

  assign busy = (state == ADD);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            c_r   <= sub | cin;
            cnt   <= '0;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          a_r <= a_r >> 1;
          b_r <= b_r >> 1;
          c_r <= c_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            sum   <= res_nxt;
            carry <= c_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
